// File: rtl/pkt_rx_pkg.sv
// Shared types for the POS-L3 receive reader.
//   rx_state_e : reader FSM states
//   rx_entry_t : one captured word plus its sidebands, as stored in the FIFO
//   mod2keep   : eop byte count (0 means 8) to MSB-first byte-enable mask
package pkt_rx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rx_state_e;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        err;
        logic [15:0] len;
    } rx_entry_t;

    function automatic logic [7:0] mod2keep(input logic [2:0] mod);
        logic [7:0] keep;
        if (mod == 3'd0) begin
            keep = 8'hFF;
        end else begin
            keep = 8'hFF << (4'd8 - {1'b0, mod});
        end
        return keep;
    endfunction

endpackage

// File: rtl/pkt_rx_fifo.sv
// Registered capture FIFO of rx_entry_t words.
//   push/push_entry : write one entry at the tail
//   pop             : drop the head entry (caller guarantees count != 0)
//   patch_tail      : force last/err on the most recently written entry, used
//                     to close a frame retroactively when a stray sop arrives
//   head            : entry at the read pointer (valid when count != 0)
//   count           : current occupancy, 0..DEPTH
// Push and pop may coincide at any occupancy. DEPTH must be a power of two.
module pkt_rx_fifo
    import pkt_rx_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk_156m25,
    input  logic          reset_156m25_n,
    input  logic          push,
    input  rx_entry_t     push_entry,
    input  logic          pop,
    input  logic          patch_tail,
    output rx_entry_t     head,
    output logic [CW-1:0] count
);

    rx_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] tail_ptr;

    assign tail_ptr = wr_ptr - AW'(1);
    assign head     = mem[rd_ptr];

    // Storage is not reset: the reader gates every output with its valid.
    always_ff @(posedge clk_156m25) begin
        if (patch_tail) begin
            mem[tail_ptr].last <= 1'b1;
            mem[tail_ptr].err  <= 1'b1;
        end
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pkt_rx_reader.sv
// Reader for the XGMAC POS-L3 receive interface. Requests words while the
// core has frames, captures the returned words into a small FIFO and presents
// them as a valid/ready stream with keep/last/err/len sidebands. Keeps
// saturating counts of delivered and errored frames.
//   pkt_rx_*  : core side (avail/ren handshake, data returns one cycle after ren)
//   m_*       : downstream stream, FIFO head
//   frame_cnt : frames delivered, err_cnt : delivered frames with m_err
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | core has no complete frame; no reads issued
//   READ  | issuing reads whenever FIFO + in-flight word leaves room for one
module pkt_rx_reader
    import pkt_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BYTES  = 16383
) (
    input  logic        clk_156m25,
    input  logic        reset_156m25_n,
    input  logic        pkt_rx_avail,
    output logic        pkt_rx_ren,
    input  logic        pkt_rx_val,
    input  logic [63:0] pkt_rx_data,
    input  logic        pkt_rx_sop,
    input  logic        pkt_rx_eop,
    input  logic [2:0]  pkt_rx_mod,
    input  logic        pkt_rx_err,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic [7:0]  m_keep,
    output logic        m_last,
    output logic        m_err,
    output logic [15:0] m_len,
    output logic [31:0] frame_cnt,
    output logic [31:0] err_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rx_state_e     state;
    rx_state_e     state_nxt;
    logic          inflight;
    logic [CW-1:0] fifo_count;
    logic          room;

    logic          in_frame;
    logic          frame_viol;
    logic [15:0]   len_acc;

    logic          frame_start;
    logic          mid_sop;
    logic [7:0]    word_keep;
    logic [3:0]    word_bytes;
    logic [15:0]   len_base;
    logic [16:0]   len_sum;
    logic [15:0]   len_new;
    logic          viol_now;
    logic          err_new;
    rx_entry_t     push_entry;
    rx_entry_t     head;

    logic          head_hold;
    logic          patch_live;
    logic          pop;

    // ---------------- request side ----------------
    assign room = ({1'b0, fifo_count} + (CW+1)'(inflight) + (CW+1)'(1))
                  <= (CW+1)'(FIFO_DEPTH);

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state    <= IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= pkt_rx_ren;
        end
    end

    always_comb begin
        state_nxt  = state;
        pkt_rx_ren = 1'b0;
        case (state)
            IDLE: begin
                if (pkt_rx_avail) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                pkt_rx_ren = room;
                if (pkt_rx_val && pkt_rx_eop && !pkt_rx_avail) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- capture side ----------------
    // A sop always starts a new frame; one arriving inside a frame also closes
    // the previous frame on its last captured word.
    always_comb begin
        frame_start = !in_frame || pkt_rx_sop;
        mid_sop     = pkt_rx_val && pkt_rx_sop && in_frame;
        word_keep   = pkt_rx_eop ? mod2keep(pkt_rx_mod) : 8'hFF;
        word_bytes  = 4'($countones(word_keep));
        len_base    = frame_start ? 16'd0 : len_acc;
        len_sum     = {1'b0, len_base} + 17'(word_bytes);
        len_new     = len_sum[16] ? 16'hFFFF : len_sum[15:0];
        viol_now    = frame_start ? !pkt_rx_sop : frame_viol;
        err_new     = pkt_rx_err || (int'(len_new) > MAX_BYTES) || viol_now;

        push_entry      = '0;
        push_entry.data = pkt_rx_data;
        push_entry.keep = word_keep;
        push_entry.last = pkt_rx_eop;
        push_entry.err  = pkt_rx_eop && err_new;
        push_entry.len  = len_new;
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            in_frame   <= 1'b0;
            frame_viol <= 1'b0;
            len_acc    <= '0;
        end else if (pkt_rx_val) begin
            in_frame   <= !pkt_rx_eop;
            frame_viol <= viol_now;
            len_acc    <= len_new;
        end
    end

    pkt_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .push           (pkt_rx_val),
        .push_entry     (push_entry),
        .pop            (pop),
        .patch_tail     (mid_sop),
        .head           (head),
        .count          (fifo_count)
    );

    // ---------------- stream side ----------------
    // A mid-frame word that is alone in the FIFO is only offered once its
    // successor is on the bus, so a stray sop can still turn it into the
    // frame's last beat before it leaves. When that successor is a stray sop
    // and the word is already at the head, the close is applied here directly.
    always_comb begin
        head_hold  = (fifo_count == CW'(1)) && !head.last && !pkt_rx_val;
        patch_live = mid_sop && (fifo_count == CW'(1));
        m_valid    = (fifo_count != '0) && !head_hold;
        m_data     = m_valid ? head.data : '0;
        m_keep     = m_valid ? head.keep : '0;
        m_len      = m_valid ? head.len  : '0;
        m_last     = m_valid && (head.last || patch_live);
        m_err      = m_valid && (head.err  || patch_live);
        pop        = m_valid && m_ready;
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else if (pop && m_last) begin
            if (frame_cnt != 32'hFFFF_FFFF) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            if (m_err && (err_cnt != 32'hFFFF_FFFF)) begin
                err_cnt <= err_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_rx_reader.sv
module tb_pkt_rx_reader;

    localparam int DEPTH = 4;
    localparam int MAXB  = 64;

    logic        clk_156m25 = 1'b0;
    logic        reset_156m25_n;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic        pkt_rx_val;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_sop;
    logic        pkt_rx_eop;
    logic [2:0]  pkt_rx_mod;
    logic        pkt_rx_err;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic [7:0]  m_keep;
    logic        m_last;
    logic        m_err;
    logic [15:0] m_len;
    logic [31:0] frame_cnt;
    logic [31:0] err_cnt;

    pkt_rx_reader #(
        .FIFO_DEPTH (DEPTH),
        .MAX_BYTES  (MAXB)
    ) dut (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .pkt_rx_avail   (pkt_rx_avail),
        .pkt_rx_ren     (pkt_rx_ren),
        .pkt_rx_val     (pkt_rx_val),
        .pkt_rx_data    (pkt_rx_data),
        .pkt_rx_sop     (pkt_rx_sop),
        .pkt_rx_eop     (pkt_rx_eop),
        .pkt_rx_mod     (pkt_rx_mod),
        .pkt_rx_err     (pkt_rx_err),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_keep         (m_keep),
        .m_last         (m_last),
        .m_err          (m_err),
        .m_len          (m_len),
        .frame_cnt      (frame_cnt),
        .err_cnt        (err_cnt)
    );

    always #5 clk_156m25 = ~clk_156m25;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  mod;
        logic        err;
    } word_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        err;
        logic [15:0] len;
    } beat_t;

    typedef struct {
        logic [15:0] len;
        logic        err;
        logic [7:0]  keep;
    } got_t;

    word_t stim_q[$];
    word_t core_q[$];
    beat_t exp_q[$];
    got_t  got_q[$];

    int tests = 0;
    int fails = 0;
    bit toggle_mode = 1'b0;
    logic ren_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] keep_of(input int nbytes);
        logic [7:0] k;
        k = 8'h00;
        for (int b = 0; b < nbytes; b++) k[7-b] = 1'b1;
        return k;
    endfunction

    function automatic int bytes_of(input word_t w);
        if (!w.eop) return 8;
        return (w.mod == 3'd0) ? 8 : int'(w.mod);
    endfunction

    task automatic emit_frame(input word_t fr[$], input bit bad);
        int    total;
        beat_t b;
        total = 0;
        foreach (fr[i]) total += bytes_of(fr[i]);
        if (total > 65535) total = 65535;
        foreach (fr[i]) begin
            b.data = fr[i].data;
            b.keep = keep_of(bytes_of(fr[i]));
            b.last = (i == fr.size() - 1);
            b.err  = b.last && (bad || (fr[i].eop && fr[i].err) || (total > MAXB));
            b.len  = 16'(total);
            exp_q.push_back(b);
        end
    endtask

    // Splits the queued word stream into frames and appends expected beats.
    task automatic model_and_load();
        word_t fr[$];
        word_t w;
        bit    viol;
        viol = 1'b0;
        foreach (stim_q[i]) begin
            w = stim_q[i];
            if (fr.size() != 0 && w.sop) begin
                emit_frame(fr, 1'b1);
                fr.delete();
            end
            if (fr.size() == 0) viol = !w.sop;
            fr.push_back(w);
            if (w.eop) begin
                emit_frame(fr, viol);
                fr.delete();
            end
            core_q.push_back(w);
        end
        stim_q.delete();
    endtask

    task automatic add_word(input logic [63:0] d, input bit sop, input bit eop,
                            input logic [2:0] mod, input bit err);
        word_t w;
        w.data = d; w.sop = sop; w.eop = eop; w.mod = mod; w.err = err;
        stim_q.push_back(w);
    endtask

    task automatic add_frame(input int id, input int nwords, input logic [2:0] mod, input bit err);
        for (int i = 0; i < nwords; i++) begin
            add_word({32'hC0DE_0000 | 32'(id), 32'h1000_0000 | 32'(i * 16'h0101)},
                     i == 0, i == nwords - 1, (i == nwords - 1) ? mod : 3'd0,
                     (i == nwords - 1) ? err : 1'b0);
        end
    endtask

    // ---------------- core model and stimulus ----------------
    always @(negedge clk_156m25) ren_seen = pkt_rx_ren;

    task automatic step();
        word_t w;
        @(posedge clk_156m25);
        #1;
        if (ren_seen && core_q.size() > 0) begin
            w = core_q.pop_front();
            pkt_rx_val  = 1'b1;
            pkt_rx_data = w.data;
            pkt_rx_sop  = w.sop;
            pkt_rx_eop  = w.eop;
            pkt_rx_mod  = w.mod;
            pkt_rx_err  = w.err;
        end else begin
            pkt_rx_val  = 1'b0;
            pkt_rx_data = '0;
            pkt_rx_sop  = 1'b0;
            pkt_rx_eop  = 1'b0;
            pkt_rx_mod  = '0;
            pkt_rx_err  = 1'b0;
        end
        pkt_rx_avail = (core_q.size() > 0);
        m_ready      = toggle_mode ? ~m_ready : 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((core_q.size() > 0 || exp_q.size() > 0) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: %0d words and %0d beats still pending after 400 cycles",
                     tag, core_q.size(), exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ren"},     pkt_rx_ren, 0);
        chk({tag, "_valid"},   m_valid,    0);
        chk({tag, "_data"},    m_data,     0);
        chk({tag, "_keep"},    m_keep,     0);
        chk({tag, "_last"},    m_last,     0);
        chk({tag, "_err"},     m_err,      0);
        chk({tag, "_len"},     m_len,      0);
        chk({tag, "_frames"},  frame_cnt,  0);
        chk({tag, "_errcnt"},  err_cnt,    0);
    endtask

    task automatic chk_got(input string tag, input int idx, input int len,
                           input bit err, input logic [7:0] keep);
        if (idx >= got_q.size()) begin
            tests++;
            fails++;
            $display("FAIL %s_missing: got %0d frames, required index %0d", tag, got_q.size(), idx);
        end else begin
            chk({tag, "_len"},  got_q[idx].len,  len);
            chk({tag, "_err"},  got_q[idx].err,  err);
            chk({tag, "_keep"}, got_q[idx].keep, keep);
        end
    endtask

    // ---------------- compare process ----------------
    int    occ = 0;
    int    mdl_frames = 0;
    int    mdl_errs = 0;
    logic  ren_d = 1'b0;
    bit    hold_pending = 1'b0;
    beat_t held;
    beat_t e;

    always @(negedge clk_156m25) begin
        if (!reset_156m25_n) begin
            occ = 0;
            ren_d = 1'b0;
            mdl_frames = 0;
            mdl_errs = 0;
            hold_pending = 1'b0;
            exp_q.delete();
        end else begin
            chk("frame_cnt", frame_cnt, 64'(mdl_frames));
            chk("err_cnt",   err_cnt,   64'(mdl_errs));

            if (hold_pending) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data",  m_data,  held.data);
                chk("hold_keep",  m_keep,  held.keep);
                chk("hold_last",  m_last,  held.last);
            end

            if (pkt_rx_ren) begin
                tests++;
                if (occ + int'(ren_d) + 1 > DEPTH) begin
                    fails++;
                    $display("FAIL ren_capacity: fifo+inflight=%0d with ren, limit %0d",
                             occ + int'(ren_d), DEPTH);
                end
            end

            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got data %0h, required no beat", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.data);
                    chk("beat_keep", m_keep, e.keep);
                    chk("beat_last", m_last, e.last);
                    if (e.last) begin
                        chk("beat_err", m_err, e.err);
                        chk("beat_len", m_len, e.len);
                        mdl_frames++;
                        if (e.err) mdl_errs++;
                    end
                end
                if (m_last) got_q.push_back('{len: m_len, err: m_err, keep: m_keep});
            end

            hold_pending = m_valid && !m_ready;
            held.data = m_data;
            held.keep = m_keep;
            held.last = m_last;

            occ = occ + int'(pkt_rx_val) - int'(m_valid && m_ready);
            if (occ > DEPTH) begin
                tests++;
                fails++;
                $display("FAIL fifo_overflow: occupancy %0d, limit %0d", occ, DEPTH);
            end
            ren_d = pkt_rx_ren;
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        reset_156m25_n = 1'b0;
        pkt_rx_avail   = 1'b0;
        pkt_rx_val     = 1'b0;
        pkt_rx_data    = '0;
        pkt_rx_sop     = 1'b0;
        pkt_rx_eop     = 1'b0;
        pkt_rx_mod     = '0;
        pkt_rx_err     = 1'b0;
        m_ready        = 1'b1;

        repeat (3) @(posedge clk_156m25);
        #1;
        chk_reset_vals("reset");
        reset_156m25_n = 1'b1;
        step();

        // T1: 64-byte frame, with request/valid latency pinned
        add_frame(1, 8, 3'd0, 1'b0);
        model_and_load();
        step();                       // cycle 0: avail rises
        chk("lat_c0_ren", pkt_rx_ren, 0);
        step();                       // cycle 1
        chk("lat_c1_ren", pkt_rx_ren, 1);
        chk("lat_c1_valid", m_valid, 0);
        step();                       // cycle 2: first word on the bus
        chk("lat_c2_valid", m_valid, 0);
        step();                       // cycle 3
        chk("lat_c3_valid", m_valid, 1);
        wait_done("t1");
        chk_got("t1", 0, 64, 1'b0, 8'hFF);
        chk("t1_frames", frame_cnt, 1);
        chk("t1_errs",   err_cnt,   0);

        // T2: 61-byte frame with core error
        add_frame(2, 8, 3'd5, 1'b1);
        model_and_load();
        wait_done("t2");
        chk_got("t2", 1, 61, 1'b1, 8'hF8);
        chk("t2_frames", frame_cnt, 2);
        chk("t2_errs",   err_cnt,   1);

        // T3: two back-to-back 3-word frames, m_ready toggling
        toggle_mode = 1'b1;
        add_frame(3, 3, 3'd2, 1'b0);
        add_frame(4, 3, 3'd7, 1'b0);
        model_and_load();
        wait_done("t3");
        toggle_mode = 1'b0;
        chk_got("t3a", 2, 18, 1'b0, 8'hC0);
        chk_got("t3b", 3, 23, 1'b0, 8'hFE);
        chk("t3_frames", frame_cnt, 4);

        // T4: 72-byte frame exceeds MAX_BYTES=64
        add_frame(5, 9, 3'd0, 1'b0);
        model_and_load();
        wait_done("t4");
        chk_got("t4", 4, 72, 1'b1, 8'hFF);
        chk("t4_errs", err_cnt, 2);

        // T5: sop on word 3 of a 5-word frame
        add_word(64'h5500_0000_0000_0001, 1'b1, 1'b0, 3'd0, 1'b0);
        add_word(64'h5500_0000_0000_0002, 1'b0, 1'b0, 3'd0, 1'b0);
        add_word(64'h5500_0000_0000_0003, 1'b1, 1'b0, 3'd0, 1'b0);
        add_word(64'h5500_0000_0000_0004, 1'b0, 1'b0, 3'd0, 1'b0);
        add_word(64'h5500_0000_0000_0005, 1'b0, 1'b1, 3'd0, 1'b0);
        model_and_load();
        wait_done("t5");
        chk_got("t5a", 5, 16, 1'b1, 8'hFF);
        chk_got("t5b", 6, 24, 1'b0, 8'hFF);
        chk("t5_frames", frame_cnt, 7);
        chk("t5_errs",   err_cnt,   3);

        // T6: frame starting without sop
        add_word(64'h6600_0000_0000_0001, 1'b0, 1'b0, 3'd0, 1'b0);
        add_word(64'h6600_0000_0000_0002, 1'b0, 1'b1, 3'd4, 1'b0);
        model_and_load();
        wait_done("t6");
        chk_got("t6", 7, 12, 1'b1, 8'hF0);
        chk("t6_errs", err_cnt, 4);

        // T7: reset after two words of a 4-word frame
        add_frame(7, 4, 3'd0, 1'b0);
        model_and_load();
        begin
            int n;
            n = 0;
            while (core_q.size() > 2 && n < 50) begin
                step();
                n++;
            end
        end
        step();
        reset_156m25_n = 1'b0;
        core_q.delete();
        pkt_rx_val   = 1'b0;
        pkt_rx_avail = 1'b0;
        #1;
        chk_reset_vals("midrst");
        step();
        step();
        reset_156m25_n = 1'b1;
        got_q.delete();
        step();
        add_frame(8, 2, 3'd1, 1'b0);
        model_and_load();
        wait_done("t7");
        chk_got("t7", 0, 9, 1'b0, 8'h80);
        chk("t7_frames", frame_cnt, 1);
        chk("t7_errs",   err_cnt,   0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pkt_rx_reader.md
# pkt_rx_reader

Consumer for the XGMAC core's POS-L3 receive interface. Watches `pkt_rx_avail`, issues `pkt_rx_ren` and captures the words the core returns one cycle later. Re-times them into a valid/ready stream with byte-enable, last, error and frame-length sidebands. Sits between the MAC core and the downstream packet logic in the `clk_156m25` domain, and keeps saturating frame and error statistics.

## Interface
- `FIFO_DEPTH`, 4: capture FIFO depth in words; power of two, ≥ 2.
- `MAX_BYTES`, 16383: largest legal frame length in bytes; longer frames are flagged.
- `clk_156m25` input 1: sole clock.
- `reset_156m25_n` input 1: asynchronous, active-low reset.
- `pkt_rx_avail` input 1: core holds at least one complete frame.
- `pkt_rx_ren` output 1: read enable to core; data returns one cycle later.
- `pkt_rx_val` input 1: `pkt_rx_data` word valid this cycle.
- `pkt_rx_data` input 64: word; first byte on [63:56].
- `pkt_rx_sop` input 1: first word of frame.
- `pkt_rx_eop` input 1: last word of frame.
- `pkt_rx_mod` input 3: valid bytes in eop word; 0 means 8.
- `pkt_rx_err` input 1: core-reported frame error, valid with eop.
- `m_valid` output 1: stream beat valid.
- `m_ready` input 1: downstream accepts beat.
- `m_data` output 64: beat data, same byte order as input.
- `m_keep` output 8: byte enables; bit 7 ↔ [63:56].
- `m_last` output 1: final beat of frame.
- `m_err` output 1: frame bad; meaningful on `m_last` beat.
- `m_len` output 16: frame byte count; meaningful on `m_last` beat.
- `frame_cnt` output 32: frames delivered (saturating).
- `err_cnt` output 32: frames delivered with `m_err` (saturating).

## Operation
- FSM states are IDLE and READ.
  - IDLE → READ when `pkt_rx_avail`=1.
  - READ → IDLE on the cycle an eop word is captured while `pkt_rx_avail`=0.
  - READ stays in READ if an eop word is captured while `pkt_rx_avail`=1.
- `pkt_rx_ren` = (state==READ) && (fifo_count + inflight + 1 ≤ FIFO_DEPTH).
  - inflight = `pkt_rx_ren` registered one cycle.
  - The FIFO therefore never overflows under any `m_ready` pattern.
- Every cycle with `pkt_rx_val`=1 pushes one entry {data, keep, eop, err, len} into the FIFO. A word arriving after eop from a speculative read is accepted as the next frame's word.
- Keep mapping:
  - Non-eop words: `m_keep`=8'hFF.
  - eop words: mod 0 → 8'hFF; mod k → 8'hFF << (8−k), e.g. mod 3 → 8'hE0.
- Length: 16-bit byte counter cleared at frame start, adds 8 per non-eop word and keep-popcount on eop.
  - Saturates at 16'hFFFF.
  - The value including the eop word is stored with that entry.
- `m_err` on the last beat = `pkt_rx_err` OR length > MAX_BYTES OR protocol violation.
- Protocol violations:
  - First word of a frame without sop.
  - sop seen mid-frame. The in-progress frame ends with `m_last`=1 and `m_err`=1 on the word preceding that sop; a new frame starts at the sop word.
- Stream: FIFO head drives `m_*`; pop when `m_valid && m_ready`. `m_data`/sidebands are held stable while `m_valid && !m_ready`.
- `frame_cnt` increments on each popped last beat. `err_cnt` also increments if `m_err`=1 on that beat. Both saturate at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - `pkt_rx_ren`=0, `m_valid`=0, `m_data`=0, `m_keep`=0, `m_last`=0, `m_err`=0, `m_len`=0.
  - `frame_cnt`=0, `err_cnt`=0.
  - State IDLE, FIFO empty, inflight=0.
- Latency from `pkt_rx_avail` rising:
  - cycle 1: `pkt_rx_ren`.
  - cycle 2: core `pkt_rx_val`.
  - cycle 3: `m_valid`. FIFO is registered, first-word fall-through one cycle after push.
- Throughput: one word per cycle sustained with `m_ready`=1 and FIFO_DEPTH ≥ 4.
- FIFO push and pop in the same cycle are allowed at any occupancy, including full.
- `pkt_rx_val` without a preceding ren is captured anyway (still within capacity accounting, since the core only returns requested words).
- Reset asserted mid-frame: all state is cleared immediately. The partial frame is discarded and not counted. After release the block restarts in IDLE.

## Structure
- Package `pkt_rx_pkg` holds:
  - state enum `rx_state_e` {IDLE, READ};
  - FIFO entry struct `rx_entry_t` {data[63:0], keep[7:0], last, err, len[15:0]};
  - function `mod2keep(logic [2:0]) → logic [7:0]`.
- Sub-module `pkt_rx_fifo`: parameterised synchronous FIFO of `rx_entry_t` with count output, async active-low reset.

## Test plan
- Single 64-byte frame (8 words, mod 0), `m_ready`=1 → 8 beats, last beat keep 8'hFF, `m_len`=64, `m_err`=0, `frame_cnt`=1.
- 61-byte frame (mod 5), `pkt_rx_err`=1 on eop → last keep 8'hF8, `m_len`=61, `m_err`=1, `err_cnt`=1.
- Two back-to-back 3-word frames with `pkt_rx_avail` held 1, `m_ready` toggling 1/0 each cycle → no dropped or duplicated words, `pkt_rx_ren` never asserted with FIFO+inflight at FIFO_DEPTH, `frame_cnt`=2.
- MAX_BYTES=64, 72-byte frame → `m_len`=72, `m_err`=1.
- sop on word 3 of a 5-word frame → word 2 carries `m_last`=1, `m_err`=1; new frame starts at word 3.
- Reset pulsed after 2 words of a 4-word frame → all outputs at reset values next cycle, counters 0, next frame delivered cleanly.
